truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper_pkg.sv | 18 +
 rtl/tt_popcount.sv | 19 +
 rtl/truth_table_sweeper.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
// Holds the FSM state encoding, the table geometry (16 indices of 4 bits),
// the counter width and the default settle time.
package truth_table_sweeper_pkg;

  localparam int unsigned N_IDX          = 16;
  localparam int unsigned IDX_W          = 4;
  localparam int unsigned CNT_W          = 5;
  localparam int unsigned SETTLE_DEFAULT = 1;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StApply  = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_popcount.sv
// 16-bit population count.
// Ports:
//   data  in  16  word to count
//   cnt   out 5   number of set bits in data (0..16)
module tt_popcount
  import truth_table_sweeper_pkg::*;
(
  input  logic [N_IDX-1:0] data,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N_IDX; i++) begin
      cnt = cnt + CNT_W'(data[i]);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps all 16 input combinations of an external 4-input function, captures
// its output into a truth table and compares it against a golden table.
// Ports:
//   clk        in  1   system clock, rising edge
//   rst_n      in  1   synchronous active-low reset
//   start      in  1   sweep request, honoured only in idle
//   abort      in  1   cancels a running sweep
//   expected   in  16  golden table, latched when start is accepted
//   x,y,w,z    out 1   function inputs, {x,y,w,z} = index
//   s          in  1   function output
//   busy       out 1   sweep in progress
//   done       out 1   one-cycle pulse on sweep completion
//   table_out  out 16  captured table
//   ones_cnt   out 5   set bits in table_out
//   err_cnt    out 5   indices differing from the latched golden table
//   pass       out 1   completed sweep with no errors
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int unsigned SETTLE = SETTLE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] expected,
  output logic        x,
  output logic        y,
  output logic        w,
  output logic        z,
  input  logic        s,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  ones_cnt,
  output logic [4:0]  err_cnt,
  output logic        pass
);

  localparam int unsigned SET_W = 4;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [N_IDX-1:0]   table_q, table_d;
  logic [N_IDX-1:0]   exp_q, exp_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic               pass_q, pass_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      settle_q <= '0;
      table_q  <= '0;
      exp_q    <= '0;
      err_q    <= '0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      settle_q <= settle_d;
      table_q  <= table_d;
      exp_q    <= exp_d;
      err_q    <= err_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    settle_d = settle_q;
    table_d  = table_q;
    exp_d    = exp_q;
    err_d    = err_q;
    pass_d   = pass_q;

    unique case (state_q)
      StIdle: begin
        // abort alongside start suppresses the start
        if (start && !abort) begin
          state_d  = StApply;
          idx_d    = '0;
          settle_d = '0;
          table_d  = '0;
          err_d    = '0;
          exp_d    = expected;
          pass_d   = 1'b0;
        end
      end
      StApply: begin
        if (abort) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d  = StSample;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      StSample: begin
        // abort takes precedence over the sample, including on the last index
        if (abort) begin
          state_d = StIdle;
          pass_d  = 1'b0;
        end else begin
          table_d[idx_q] = s;
          if (s != exp_q[idx_q]) begin
            err_d = err_q + CNT_W'(1);
          end
          if (idx_q == IDX_W'(N_IDX - 1)) begin
            state_d = StDone;
            pass_d  = (err_d == '0);
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = StApply;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy = (state_q == StApply) || (state_q == StSample);
  assign done = (state_q == StDone);

  // Function inputs are only driven while sweeping; idle and done show zero.
  assign {x, y, w, z} = busy ? idx_q : '0;

  assign table_out = table_q;
  assign err_cnt   = err_q;
  assign pass      = pass_q;

  tt_popcount u_popcount (
    .data (table_q),
    .cnt  (ones_cnt)
  );

endmodule
